// File: rtl/alu_decoder_if.sv
// Decode request (in_valid, alu_op, funct3, funct7b5) and registered result bundle.
// master drives the request and observes the result; slave is the decoder.
interface alu_decoder_if;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] alu_control;
  logic       out_valid;
  logic       illegal;

  modport master (
    output in_valid,
    output alu_op,
    output funct3,
    output funct7b5,
    input  alu_control,
    input  out_valid,
    input  illegal
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  funct3,
    input  funct7b5,
    output alu_control,
    output out_valid,
    output illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Registered RISC-V ALU control decoder with an illegal-encoding flag.
// 1-cycle latency, one decode per cycle; no backpressure, results hold while in_valid is low.
module alu_decoder (
  input  logic          clk,
  input  logic          rst_n,
  alu_decoder_if.slave  bus
);

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  logic [3:0] dec_control;
  logic       dec_illegal;
  logic [3:0] control_q;
  logic       illegal_q;
  logic       valid_q;

  // funct7b5 is only read in the ADD/SUB arm so an X on it cannot leak elsewhere.
  always_comb begin
    dec_control = ALU_ADD;
    dec_illegal = 1'b0;
    case (bus.alu_op)
      OP_MEM:    dec_control = ALU_ADD;
      OP_BRANCH: dec_control = ALU_SUB;
      OP_RTYPE: begin
        case (bus.funct3)
          F3_ADD_SUB: begin
            if (bus.funct7b5 == 1'b1) dec_control = ALU_SUB;
            else                      dec_control = ALU_ADD;
          end
          F3_AND:  dec_control = ALU_AND;
          F3_OR:   dec_control = ALU_OR;
          F3_SLT:  dec_control = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_q <= ALU_ADD;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        control_q <= dec_control;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign bus.alu_control = control_q;
  assign bus.illegal     = illegal_q;
  assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Randomized scoreboard bench for alu_decoder: stimulus pushes expected outputs per cycle,
// a monitor pops and compares one cycle later.
module tb_alu_decoder;

  typedef struct {
    bit         vld;
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_decoder_if bus ();

  alu_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result per funct3 for R-type ops other than the ADD/SUB slot; unsupported rows flag illegal.
  logic [3:0] rtype_ctrl [8] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd3, 4'd2};
  bit         rtype_ok   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  exp_t       sb_q [$];
  logic [3:0] hold_ctrl;
  logic       hold_ill;
  int         n_cmp;
  int         n_err;

  function automatic exp_t ref_model(bit [1:0] op, bit [2:0] f3, logic f7);
    exp_t r;
    r.vld  = 1'b1;
    r.ctrl = 4'd0;
    r.ill  = 1'b0;
    if (op == 2'd1) r.ctrl = 4'd1;
    else if (op == 2'd3) r.ill = 1'b1;
    else if (op == 2'd2) begin
      if (f3 == 3'd0) r.ctrl = (f7 === 1'b1) ? 4'd1 : 4'd0;
      else begin
        r.ctrl = rtype_ctrl[f3];
        r.ill  = !rtype_ok[f3];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got vld/ctrl/ill=%b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Drive inputs now and record what the outputs must show after the next rising edge.
  task automatic apply(input bit v, input bit [1:0] op, input bit [2:0] f3, input logic f7);
    exp_t e;
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    if (v) begin
      e = ref_model(op, f3, f7);
      hold_ctrl = e.ctrl;
      hold_ill  = e.ill;
    end else begin
      e.vld  = 1'b0;
      e.ctrl = hold_ctrl;
      e.ill  = hold_ill;
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit v, input bit [1:0] op, input bit [2:0] f3, input logic f7);
    @(negedge clk);
    apply(v, op, f3, f7);
  endtask

  task automatic randomize_inputs();
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'($urandom);
    bus.funct3   = 3'($urandom);
    bus.funct7b5 = 1'($urandom);
  endtask

  // Monitor: checks every cycle, decoupled from the stimulus process.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      check("reset_hold", {bus.out_valid, bus.alu_control, bus.illegal}, 6'b0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.vld ? "decode" : "hold",
            {bus.out_valid, bus.alu_control, bus.illegal}, {e.vld, e.ctrl, e.ill});
    end else begin
      check("idle", {bus.out_valid, bus.alu_control, bus.illegal}, {1'b0, hold_ctrl, hold_ill});
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    hold_ctrl = 4'd0;
    hold_ill  = 1'b0;
    rst_n = 1'b0;
    randomize_inputs();

    // Reset with toggling inputs, then a fresh sample on the first edge after release.
    repeat (4) begin
      @(negedge clk);
      randomize_inputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'b10, 3'b111, 1'b0);

    // Fixed ops, with and without random funct fields.
    drive(1'b1, 2'b00, 3'b000, 1'b0);
    drive(1'b1, 2'b01, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 3'($urandom), 1'($urandom));
      drive(1'b1, 2'b01, 3'($urandom), 1'($urandom));
    end

    // R-type arithmetic and logic/compare with funct7b5 unknown.
    drive(1'b1, 2'b10, 3'b000, 1'b0);
    drive(1'b1, 2'b10, 3'b000, 1'b1);
    drive(1'b1, 2'b10, 3'b111, 1'bx);
    drive(1'b1, 2'b10, 3'b110, 1'bx);
    drive(1'b1, 2'b10, 3'b010, 1'bx);
    drive(1'b1, 2'b00, 3'b101, 1'bx);

    // Unsupported encodings, then a supported one clears the flag.
    drive(1'b1, 2'b10, 3'b001, 1'b0);
    drive(1'b1, 2'b11, 3'b000, 1'b0);
    drive(1'b1, 2'b10, 3'b111, 1'b1);

    // Hold: SUB followed by idle cycles with changing inputs.
    drive(1'b1, 2'b01, 3'b000, 1'b0);
    drive(1'b0, 2'b10, 3'b111, 1'b0);
    drive(1'b0, 2'b11, 3'b001, 1'b1);
    drive(1'b0, 2'b10, 3'b110, 1'b0);

    // Back-to-back ADD/AND/OR.
    drive(1'b1, 2'b10, 3'b000, 1'b0);
    drive(1'b1, 2'b10, 3'b111, 1'b0);
    drive(1'b1, 2'b10, 3'b110, 1'b0);

    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom));

    // Asynchronous reset mid-cycle with a decode pending on the inputs.
    @(negedge clk);
    randomize_inputs();
    bus.alu_op = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.out_valid, bus.alu_control, bus.illegal}, 6'b0);
    sb_q.delete();
    hold_ctrl = 4'd0;
    hold_ill  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      randomize_inputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'b01, 3'b000, 1'b0);

    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom));
    drive(1'b0, 2'b00, 3'b000, 1'b0);

    begin
      int budget;
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (sb_q.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
    end
    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
